// File: rtl/spi_pkg.sv
// Shared types and SPI mode constants for the SPI transmit path.
// Mode 0 only: sclk idles low, data launched on falling edges.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        LEAD  = 3'd2,
        SHIFT = 3'd3,
        TRAIL = 3'd4
    } spi_tx_state_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period counter and registered SPI clock.
// tc marks the last cycle of a half period; rise/fall predict sclk edges.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic count,
    input  logic run,
    output logic tc,
    output logic rise,
    output logic fall,
    output logic sclk
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    assign tc   = count && (cnt == TC_VAL);
    assign rise = run && tc && (sclk == CPOL);
    assign fall = run && tc && (sclk != CPOL);

    // half-period counter, held clear whenever timing is not needed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!count || tc)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // sclk toggles at each terminal count while shifting, else idles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sclk <= CPOL;
        else if (!run)
            sclk <= CPOL;
        else if (tc)
            sclk <= ~sclk;
    end

endmodule

// File: rtl/spi_tx_ctrl.sv
// SPI mode-0 transmit controller: host handshake, frame FSM,
// shifter load/shift strobes, sclk and chip select generation.
module spi_tx_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HALF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic [WIDTH-1:0] ser_data,
    output logic             ser_load,
    output logic             ser_enable,
    output logic             sclk,
    output logic             cs_n,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    spi_tx_state_t state;
    logic [BW-1:0] bit_cnt;
    logic          tc;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          count;
    logic          run;
    logic          accept;

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign ser_load = (state == LOAD);
    assign accept   = tx_valid && tx_ready;
    assign run      = (state == SHIFT);
    assign count    = (state == LEAD) || (state == SHIFT)
                   || (state == TRAIL);

    spi_sclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sclk (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .run   (run),
        .tc    (tc),
        .rise  (sclk_rise),
        .fall  (sclk_fall),
        .sclk  (sclk)
    );

    // frame sequencer: accept, load, lead-in, shift, chip-select hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            ser_data   <= '0;
            ser_enable <= 1'b0;
            cs_n       <= 1'b1;
            done       <= 1'b0;
        end else begin
            ser_enable <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ser_data <= tx_data;
                        cs_n     <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: state <= LEAD;
                LEAD: begin
                    if (tc)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= TRAIL;
                        end else begin
                            bit_cnt    <= bit_cnt + BW'(1);
                            ser_enable <= 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (tc) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        cs_n    <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rising sclk edges may only be scheduled inside the shift phase
    a_rise_in_shift: assert property (
        @(posedge clk) disable iff (!rst) sclk_rise |-> (state == SHIFT)
    );

endmodule

// File: tb/tb_spi_tx_ctrl.sv
// Self-checking bench for spi_tx_ctrl: default instance plus a
// WIDTH=16/HALF_DIV=3 instance, checked against a frame-level model.
module tb_spi_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       tx_valid_a = 1'b0;
    logic [7:0] tx_data_a = '0;
    logic       rdy_a, load_a, en_a, sclk_a, cs_a, busy_a, done_a;
    logic [7:0] data_a;

    logic        tx_valid_b = 1'b0;
    logic [15:0] tx_data_b = '0;
    logic        rdy_b, load_b, en_b, sclk_b, cs_b, busy_b, done_b;
    logic [15:0] data_b;

    spi_tx_ctrl dut_a (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid_a),
        .tx_data    (tx_data_a),
        .tx_ready   (rdy_a),
        .ser_data   (data_a),
        .ser_load   (load_a),
        .ser_enable (en_a),
        .sclk       (sclk_a),
        .cs_n       (cs_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    spi_tx_ctrl #(
        .WIDTH    (16),
        .HALF_DIV (3)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid_b),
        .tx_data    (tx_data_b),
        .tx_ready   (rdy_b),
        .ser_data   (data_b),
        .ser_load   (load_b),
        .ser_enable (en_b),
        .sclk       (sclk_b),
        .cs_n       (cs_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    localparam int LAT_A = 1 + 2 * (2 * 8 + 2);
    localparam int LAT_B = 1 + 3 * (2 * 16 + 2);

    int passed = 0;
    int total  = 0;

    int cyc = 0;
    int rises, falls, loads, ens, en_bad, rdy_bad;
    int done_cnt, done_cyc, acc_cnt, acc_cyc, acc1_cyc;
    int cs_low, gap_run, last_gap;
    logic [7:0] sh_a = '0;
    logic       pa_sclk = 1'b0;
    logic       pa_cs = 1'b1;
    logic       bits_q[$];

    task automatic clr_a();
        rises = 0; falls = 0; loads = 0; ens = 0;
        en_bad = 0; rdy_bad = 0; done_cnt = 0;
        done_cyc = -1; acc_cnt = 0; acc_cyc = -1;
        acc1_cyc = -1; cs_low = 0; gap_run = 0;
        last_gap = -1;
        bits_q.delete();
    endtask

    // one clk cycle of the default instance, observed at negedge
    task automatic tick_a();
        logic pre, fell;
        pre = tx_valid_a && rdy_a;
        @(negedge clk);
        cyc++;
        if (pre) begin
            acc_cnt++;
            if (acc_cnt == 1) acc1_cyc = cyc;
            acc_cyc = cyc;
        end
        fell = pa_sclk && !sclk_a;
        if (sclk_a && !pa_sclk) begin
            rises++;
            bits_q.push_back(sh_a[7]);
        end
        if (fell) begin
            falls++;
            if (en_a !== ((falls % 8) != 0)) en_bad++;
        end else if (en_a) begin
            en_bad++;
        end
        if (en_a) ens++;
        if (load_a) loads++;
        if (done_a) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!cs_a) cs_low++;
        if (!cs_a && rdy_a) rdy_bad++;
        if (cs_a) begin
            gap_run++;
        end else begin
            if (pa_cs) last_gap = gap_run;
            gap_run = 0;
        end
        if (load_a) sh_a = data_a;
        else if (en_a) sh_a = {sh_a[6:0], 1'b0};
        pa_sclk = sclk_a;
        pa_cs = cs_a;
    endtask

    function automatic logic [15:0] packq();
        logic [15:0] v;
        v = '0;
        foreach (bits_q[i]) v = {v[14:0], bits_q[i]};
        return v;
    endfunction

    task automatic send_a(input logic [7:0] w);
        tx_data_a = w;
        tx_valid_a = 1'b1;
        tick_a();
        tx_valid_a = 1'b0;
    endtask

    task automatic wait_done_a(input int n);
        int k;
        k = 0;
        while (done_cnt < n && k < 200) begin
            tick_a();
            k++;
        end
        if (done_cnt < n) begin
            total++;
            $display("FAIL done_timeout: got %0d dones, want %0d",
                     done_cnt, n);
        end
    endtask

    task automatic test_reset();
        logic [6:0] exp_c;
        exp_c = 7'b1100000;
        rst = 1'b0;
        #12;
        total++;
        if ({rdy_a, cs_a, sclk_a, load_a, en_a, busy_a, done_a} !== exp_c)
            $display("FAIL reset_ctrl_a: got %b want %b",
                {rdy_a, cs_a, sclk_a, load_a, en_a, busy_a, done_a}, exp_c);
        else passed++;
        total++;
        if (data_a !== 8'h00)
            $display("FAIL reset_data_a: got %h want 00", data_a);
        else passed++;
        total++;
        if ({rdy_b, cs_b, sclk_b, load_b, en_b, busy_b, done_b} !== exp_c)
            $display("FAIL reset_ctrl_b: got %b want %b",
                {rdy_b, cs_b, sclk_b, load_b, en_b, busy_b, done_b}, exp_c);
        else passed++;
        total++;
        if (data_b !== 16'h0000)
            $display("FAIL reset_data_b: got %h want 0000", data_b);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick_a();
    endtask

    task automatic test_single();
        clr_a();
        send_a(8'hA5);
        wait_done_a(1);
        total++;
        if (done_cyc - acc_cyc !== LAT_A)
            $display("FAIL single_latency: got %0d want %0d",
                     done_cyc - acc_cyc, LAT_A);
        else passed++;
        total++;
        if (cs_low !== LAT_A)
            $display("FAIL single_cs_low: got %0d want %0d", cs_low, LAT_A);
        else passed++;
        total++;
        if (rises !== 8)
            $display("FAIL single_rises: got %0d want 8", rises);
        else passed++;
        total++;
        if (packq() !== 16'h00A5 || bits_q.size() != 8)
            $display("FAIL single_bits: got %h want a5", packq());
        else passed++;
        repeat (3) tick_a();
        total++;
        if (done_cnt !== 1)
            $display("FAIL single_done_cnt: got %0d want 1", done_cnt);
        else passed++;
    endtask

    task automatic test_enable_count();
        clr_a();
        send_a(8'hFF);
        wait_done_a(1);
        repeat (4) tick_a();
        total++;
        if (loads !== 1)
            $display("FAIL en_loads: got %0d want 1", loads);
        else passed++;
        total++;
        if (ens !== 7)
            $display("FAIL en_count: got %0d want 7", ens);
        else passed++;
        total++;
        if (en_bad !== 0)
            $display("FAIL en_align: got %0d misaligned want 0", en_bad);
        else passed++;
        total++;
        if (falls !== 8)
            $display("FAIL en_falls: got %0d want 8", falls);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int k;
        int d1;
        clr_a();
        tx_data_a = 8'h81;
        tx_valid_a = 1'b1;
        tick_a();
        tx_data_a = 8'h3C;
        k = 0;
        d1 = -1;
        while (acc_cnt < 2 && k < 200) begin
            tick_a();
            if (done_cnt == 1 && d1 < 0) d1 = done_cyc;
            k++;
        end
        tx_valid_a = 1'b0;
        wait_done_a(2);
        repeat (2) tick_a();
        total++;
        if (acc_cyc !== d1 + 1)
            $display("FAIL b2b_accept_in_done: accept %0d done %0d",
                     acc_cyc, d1);
        else passed++;
        total++;
        if (last_gap !== 1)
            $display("FAIL b2b_cs_gap: got %0d want 1", last_gap);
        else passed++;
        total++;
        if (packq() !== 16'h813C || bits_q.size() != 16)
            $display("FAIL b2b_bits: got %h want 813c", packq());
        else passed++;
        total++;
        if (done_cyc - acc_cyc !== LAT_A)
            $display("FAIL b2b_latency2: got %0d want %0d",
                     done_cyc - acc_cyc, LAT_A);
        else passed++;
        total++;
        if (d1 - acc1_cyc !== LAT_A)
            $display("FAIL b2b_latency1: got %0d want %0d",
                     d1 - acc1_cyc, LAT_A);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        clr_a();
        send_a(8'hC3);
        repeat (10) tick_a();
        tx_data_a = 8'h00;
        tx_valid_a = 1'b1;
        tick_a();
        tx_valid_a = 1'b0;
        wait_done_a(1);
        repeat (2) tick_a();
        total++;
        if (acc_cnt !== 1)
            $display("FAIL busy_accepts: got %0d want 1", acc_cnt);
        else passed++;
        total++;
        if (packq() !== 16'h00C3 || bits_q.size() != 8)
            $display("FAIL busy_bits: got %h want c3", packq());
        else passed++;
        total++;
        if (rdy_bad !== 0)
            $display("FAIL busy_ready: got %0d ready cycles want 0",
                     rdy_bad);
        else passed++;
        total++;
        if (loads !== 1)
            $display("FAIL busy_loads: got %0d want 1", loads);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int k;
        logic [6:0] got;
        clr_a();
        send_a(8'($urandom));
        k = 0;
        while (rises < 3 && k < 200) begin
            tick_a();
            k++;
        end
        total++;
        if (rises < 3)
            $display("FAIL rmid_rises: got %0d want 3", rises);
        else passed++;
        #2 rst = 1'b0;
        #1;
        got = {rdy_a, cs_a, sclk_a, load_a, en_a, busy_a, done_a};
        total++;
        if (got !== 7'b1100000)
            $display("FAIL rmid_async: got %b want 1100000", got);
        else passed++;
        total++;
        if (data_a !== 8'h00)
            $display("FAIL rmid_data: got %h want 00", data_a);
        else passed++;
        repeat (3) tick_a();
        rst = 1'b1;
        repeat (5) tick_a();
        total++;
        if (done_cnt !== 0)
            $display("FAIL rmid_no_done: got %0d want 0", done_cnt);
        else passed++;
        clr_a();
        send_a(8'h5A);
        wait_done_a(1);
        total++;
        if (packq() !== 16'h005A || bits_q.size() != 8)
            $display("FAIL rmid_bits: got %h want 5a", packq());
        else passed++;
        total++;
        if (done_cyc - acc_cyc !== LAT_A)
            $display("FAIL rmid_latency: got %0d want %0d",
                     done_cyc - acc_cyc, LAT_A);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] w;
        for (int n = 0; n < 6; n++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick_a();
            clr_a();
            send_a(w);
            wait_done_a(1);
            total++;
            if (packq() !== {8'h00, w} || bits_q.size() != 8)
                $display("FAIL rand_bits[%0d]: got %h want %h",
                         n, packq(), w);
            else passed++;
            total++;
            if (done_cyc - acc_cyc !== LAT_A)
                $display("FAIL rand_latency[%0d]: got %0d want %0d",
                         n, done_cyc - acc_cyc, LAT_A);
            else passed++;
        end
    endtask

    task automatic test_sweep();
        logic [15:0] words [2];
        logic [15:0] sh, got;
        int acc, dn, r;
        logic ps, pre;
        words[0] = 16'h8001;
        words[1] = 16'($urandom);
        for (int k = 0; k < 2; k++) begin
            sh = '0; got = '0; r = 0; acc = -1; dn = -1;
            ps = sclk_b;
            tx_data_b = words[k];
            tx_valid_b = 1'b1;
            for (int c = 1; c <= 300 && dn < 0; c++) begin
                pre = tx_valid_b && rdy_b;
                @(negedge clk);
                tx_valid_b = 1'b0;
                if (pre) acc = c;
                if (sclk_b && !ps) begin
                    r++;
                    got = {got[14:0], sh[15]};
                end
                if (done_b) dn = c;
                if (load_b) sh = data_b;
                else if (en_b) sh = {sh[14:0], 1'b0};
                ps = sclk_b;
            end
            total++;
            if (dn < 0 || dn - acc !== LAT_B)
                $display("FAIL sweep_latency[%0d]: got %0d want %0d",
                         k, dn - acc, LAT_B);
            else passed++;
            total++;
            if (r !== 16)
                $display("FAIL sweep_rises[%0d]: got %0d want 16", k, r);
            else passed++;
            total++;
            if (got !== words[k])
                $display("FAIL sweep_bits[%0d]: got %h want %h",
                         k, got, words[k]);
            else passed++;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        clr_a();
        test_reset();
        test_single();
        test_enable_count();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
